// File: rtl/branch_resolve.sv
// LEGv8 branch resolution: condition evaluation with NZCV forwarding, target select and
// mispredict detection behind a valid/ready result port. Define BRANCH_RESOLVE_STATS_EN for counters.
module branch_resolve #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [3:0]       in_cond,
    input  logic             in_zero,
    input  logic [63:0]      in_pc,
    input  logic [63:0]      in_offset,
    input  logic             in_pred_taken,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flag_we,
    input  logic [3:0]       flag_nzcv,
    input  logic             flags_busy,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [63:0]      out_target,
    output logic             out_mispredict,
    output logic [TAG_W-1:0] out_tag
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]      stat_resolved,
    output logic [31:0]      stat_mispredict
`endif
);

    localparam logic [1:0] OpCbz   = 2'b00;
    localparam logic [1:0] OpCbnz  = 2'b01;
    localparam logic [1:0] OpBcond = 2'b10;
    localparam logic [1:0] OpB     = 2'b11;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StWaitFlags = 2'b01,
        StDone      = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [3:0]       nzcv_q;
    logic [1:0]       op_q;
    logic [3:0]       cond_q;
    logic             zero_q;
    logic [63:0]      pc_q;
    logic [63:0]      offset_q;
    logic             pred_q;
    logic [TAG_W-1:0] tag_q;

    logic             taken_q;
    logic [63:0]      target_q;
    logic             mispredict_q;
    logic [TAG_W-1:0] res_tag_q;

    logic             capture;
    logic             resolve;
    logic [1:0]       sel_op;
    logic [3:0]       sel_cond;
    logic             sel_zero;
    logic [63:0]      sel_pc;
    logic [63:0]      sel_offset;
    logic             sel_pred;
    logic [TAG_W-1:0] sel_tag;
    logic [3:0]       nzcv_now;
    logic             taken_d;
    logic [63:0]      target_d;

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'd0:    res = z;
            4'd1:    res = !z;
            4'd2:    res = c;
            4'd3:    res = !c;
            4'd4:    res = n;
            4'd5:    res = !n;
            4'd6:    res = v;
            4'd7:    res = !v;
            4'd8:    res = c && !z;
            4'd9:    res = !c || z;
            4'd10:   res = (n == v);
            4'd11:   res = (n != v);
            4'd12:   res = !z && (n == v);
            4'd13:   res = z || (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    function automatic logic branch_taken(input logic [1:0] op, input logic [3:0] cond,
                                          input logic zero, input logic [3:0] nzcv);
        logic res;
        case (op)
            OpCbz:   res = zero;
            OpCbnz:  res = !zero;
            OpBcond: res = cond_holds(cond, nzcv);
            OpB:     res = 1'b1;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // A flag write in the resolving cycle is visible to that cycle's evaluation.
    assign nzcv_now = flag_we ? flag_nzcv : nzcv_q;

    // In IDLE the branch resolves straight from the inputs; otherwise from the held copy.
    always_comb begin
        if (state_q == StIdle) begin
            sel_op     = in_op;
            sel_cond   = in_cond;
            sel_zero   = in_zero;
            sel_pc     = in_pc;
            sel_offset = in_offset;
            sel_pred   = in_pred_taken;
            sel_tag    = in_tag;
        end else begin
            sel_op     = op_q;
            sel_cond   = cond_q;
            sel_zero   = zero_q;
            sel_pc     = pc_q;
            sel_offset = offset_q;
            sel_pred   = pred_q;
            sel_tag    = tag_q;
        end
    end

    assign taken_d  = branch_taken(sel_op, sel_cond, sel_zero, nzcv_now);
    assign target_d = taken_d ? (sel_pc + sel_offset) : (sel_pc + 64'd4);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        resolve = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    capture = 1'b1;
                    if (in_op == OpBcond && flags_busy) begin
                        state_d = StWaitFlags;
                    end else begin
                        state_d = StDone;
                        resolve = 1'b1;
                    end
                end
            end
            StWaitFlags: begin
                if (!flags_busy) begin
                    state_d = StDone;
                    resolve = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flush wins over acceptance and over the result handshake.
        if (flush) begin
            state_d = StIdle;
            capture = 1'b0;
            resolve = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            nzcv_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (flag_we) begin
                nzcv_q <= flag_nzcv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 2'b00;
            cond_q   <= 4'b0000;
            zero_q   <= 1'b0;
            pc_q     <= 64'd0;
            offset_q <= 64'd0;
            pred_q   <= 1'b0;
            tag_q    <= '0;
        end else if (capture) begin
            op_q     <= in_op;
            cond_q   <= in_cond;
            zero_q   <= in_zero;
            pc_q     <= in_pc;
            offset_q <= in_offset;
            pred_q   <= in_pred_taken;
            tag_q    <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q      <= 1'b0;
            target_q     <= 64'd0;
            mispredict_q <= 1'b0;
            res_tag_q    <= '0;
        end else if (resolve) begin
            taken_q      <= taken_d;
            target_q     <= target_d;
            mispredict_q <= taken_d ^ sel_pred;
            res_tag_q    <= sel_tag;
        end
    end

    assign in_ready       = (state_q == StIdle);
    assign out_valid      = (state_q == StDone);
    assign out_taken      = taken_q;
    assign out_target     = target_q;
    assign out_mispredict = mispredict_q;
    assign out_tag        = res_tag_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic        handshake;
    logic [31:0] stat_resolved_q;
    logic [31:0] stat_mispredict_q;

    assign handshake = (state_q == StDone) && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved_q   <= 32'd0;
            stat_mispredict_q <= 32'd0;
        end else if (handshake) begin
            if (stat_resolved_q != 32'hFFFF_FFFF) begin
                stat_resolved_q <= stat_resolved_q + 32'd1;
            end
            if (mispredict_q && stat_mispredict_q != 32'hFFFF_FFFF) begin
                stat_mispredict_q <= stat_mispredict_q + 32'd1;
            end
        end
    end

    assign stat_resolved   = stat_resolved_q;
    assign stat_mispredict = stat_mispredict_q;
`endif

endmodule
